// File: rtl/instr_encoder_loader.sv
// Encodes MIPS-style instruction requests into 32-bit words and streams them
// into an instruction memory, one word per two cycles, until DEPTH words are loaded.
module instr_encoder_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op_sel,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] idx;
    logic [31:0]   enc;
    logic          legal;
    logic          hs;

    assign in_ready = (state == IDLE) && !clear && !rst;
    assign hs       = in_valid && in_ready;
    // A write cycle in flight is dropped the moment rst is seen.
    assign mem_we   = (state == WRITE) && !rst;
    assign full     = (count == FULL_CNT);

    always_comb begin
        legal = 1'b1;
        enc   = '0;
        case (op_sel)
            4'd0:    enc = {6'd0, rs, rt, rd, 5'd0, 6'd32};
            4'd1:    enc = {6'd0, rs, rt, rd, 5'd0, 6'd34};
            4'd2:    enc = {6'd0, rs, rt, rd, 5'd0, 6'd42};
            4'd3:    enc = {6'd0, rs, 15'd0, 6'd8};
            4'd4:    enc = {6'd8,  rs, rt, imm};
            4'd5:    enc = {6'd10, rs, rt, imm};
            4'd6:    enc = {6'd35, rs, rt, imm};
            4'd7:    enc = {6'd43, rs, rt, imm};
            4'd8:    enc = {6'd2, target};
            4'd9:    enc = {6'd3, target};
            4'd10:   enc = {6'd4, rs, rt, imm};
            4'd11:   enc = {6'd5, rs, rt, imm};
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs && legal) state_nxt = WRITE;
            WRITE:   state_nxt = (count == LAST_CNT) ? FULL : IDLE;
            FULL:    state_nxt = FULL;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            count     <= '0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (hs) begin
                if (legal) begin
                    mem_addr  <= {{(30-AW){1'b0}}, idx, 2'b00};
                    mem_wdata <= enc;
                end else begin
                    err <= 1'b1;
                end
            end
            if (state == WRITE) begin
                idx   <= idx + 1'b1;
                count <= count + 1'b1;
            end
            // hs is already masked by clear, so only the counters need overriding.
            if (clear) begin
                idx   <= '0;
                count <= '0;
                err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4) with a queue-based write scoreboard.
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst, clear, in_valid, in_ready;
    logic [3:0]    op_sel;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          mem_we;
    logic [31:0]   mem_addr, mem_wdata;
    logic [AW:0]   count;
    logic          full, err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  exp_idx = 0;

    instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
                chk("ready_in_write", {31'd0, in_ready}, 32'd0);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg,
                        input logic legal, input logic [31:0] word);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        op_sel = op; rs = s; rt = t; rd = d; imm = im; target = tg;
        in_valid = 1'b1;
        if (legal) begin
            q.push_back('{addr: 32'(exp_idx * 4), data: word});
            exp_idx = (exp_idx + 1) % DEPTH;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_sel = 4'($urandom_range(0, 15));
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        imm = 16'($urandom); target = 26'($urandom);
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_idx = 0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_full", {31'd0, full}, 32'd0);
        chk("clr_err", {31'd0, err}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        op_sel = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
        @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full_err", {30'd0, full, err}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD rs=1 rt=2 rd=3
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h00221820);
        @(negedge clk);
        chk("add_count", 32'(count), 32'd1);
        do_clear();

        // LW then BEQ back to back
        send(4'd6, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1, 32'h8FA80004);
        send(4'd10, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b1, 32'h1022FFFF);
        @(negedge clk);
        chk("lw_beq_count", 32'(count), 32'd2);
        do_clear();

        // JR with rt/rd driven, then JAL
        send(4'd3, 5'd31, 5'd5, 5'd7, 16'h0, 26'h0, 1'b1, 32'h03E00008);
        send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 32'h0C000010);
        @(negedge clk);
        do_clear();

        // Illegal op, then SUB
        send(4'd13, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h0);
        chk("illegal_err", {31'd0, err}, 32'd1);
        chk("illegal_count", 32'(count), 32'd0);
        send(4'd1, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00000022);
        @(negedge clk);
        chk("sub_count", 32'(count), 32'd1);
        chk("err_sticky", {31'd0, err}, 32'd1);
        do_clear();

        // Fill to DEPTH with the remaining formats
        send(4'd4, 5'd2, 5'd3, 5'd0, 16'h1234, 26'h0, 1'b1, 32'h20431234);
        send(4'd5, 5'd4, 5'd5, 5'd0, 16'h8000, 26'h0, 1'b1, 32'h28858000);
        send(4'd7, 5'd29, 5'd31, 5'd0, 16'h0008, 26'h0, 1'b1, 32'hAFBF0008);
        send(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF);
        @(negedge clk);
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_count", 32'(count), 32'd4);
        // Fifth request must stall with no write
        op_sel = 4'd0; rs = 5'd1; rt = 5'd1; rd = 5'd1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("full_hold_count", 32'(count), 32'd4);
        do_clear();

        // SLT at 0, then BNE with clear landing in its write cycle
        send(4'd2, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b1, 32'h00A6382A);
        send(4'd11, 5'd3, 5'd4, 5'd0, 16'hFFFE, 26'h0, 1'b1, 32'h1464FFFE);
        do_clear();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h00221820);
        @(negedge clk);
        chk("post_clear_count", 32'(count), 32'd1);

        // rst in the cycle after a handshake drops the write
        while (in_ready !== 1'b1) @(negedge clk);
        op_sel = 4'd6; rs = 5'd29; rt = 5'd8; imm = 16'h0004; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drop_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("rst2_count", 32'(count), 32'd0);
        chk("rst2_addr", mem_addr, 32'd0);
        chk("rst2_wdata", mem_wdata, 32'd0);
        chk("rst2_flags", {29'd0, full, err, in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("missing_writes", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
